fifo_stream_reader: RTL and testbench

//  Read-side master for the project fifo: pops words via r_ready/fifo_empty/data_out,

---
 rtl/fifo_stream_reader.sv | 161 ++++++++++++++++
 tb/tb_fifo_stream_reader.sv | 260 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_stream_reader.sv
// Read-side master for the project fifo: pops words, holds them in a 3-entry skid buffer
// and forwards them as a framed valid/ready stream. Optional SEQ_CHECK_EN adds a sequence checker.
module fifo_stream_reader #(
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned BURST_LEN = 4,
    parameter int unsigned CNT_W     = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             enable,
    input  logic             fifo_empty,
    output logic             r_ready,
    input  logic [WIDTH-1:0] data_in,
    output logic             m_valid,
    input  logic             m_ready,
    output logic [WIDTH-1:0] m_data,
    output logic             m_last,
    output logic             busy,
    output logic [CNT_W-1:0] rd_count,
    output logic             seq_err
);

    localparam int unsigned BeatW = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam logic [BeatW-1:0] LastBeat = BeatW'(BURST_LEN - 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDrain
    } state_e;

    state_e state_q, state_d;

    logic [1:0]       occ_q, occ_d;
    logic             inflight_q, inflight_d;
    logic [1:0]       head_q, head_d;
    logic [1:0]       tail_q, tail_d;
    logic [WIDTH-1:0] buf_q [3];
    logic [BeatW-1:0] beat_q, beat_d;
    logic [CNT_W-1:0] rd_count_q, rd_count_d;

    logic fire;
    logic capture;

    function automatic logic [1:0] ptr_inc(input logic [1:0] p);
        return (p == 2'd2) ? 2'd0 : p + 2'd1;
    endfunction

    // Pop gating counts the in-flight word so the buffer can never overflow.
    always_comb begin
        r_ready = (state_q == StRun) && !fifo_empty &&
                  (({1'b0, occ_q} + {2'b00, inflight_q}) < 3'd3);
        m_valid = (occ_q != 2'd0);
        m_data  = buf_q[head_q];
        m_last  = m_valid && (beat_q == LastBeat);
        busy    = (state_q != StIdle);
        fire    = m_valid && m_ready;
        capture = inflight_q;
    end

    always_comb begin
        occ_d      = occ_q;
        head_d     = head_q;
        tail_d     = tail_q;
        beat_d     = beat_q;
        rd_count_d = rd_count_q;
        inflight_d = r_ready;

        unique case ({capture, fire})
            2'b10:   occ_d = occ_q + 2'd1;
            2'b01:   occ_d = occ_q - 2'd1;
            default: occ_d = occ_q;
        endcase

        if (capture) begin
            tail_d = ptr_inc(tail_q);
        end
        if (fire) begin
            head_d     = ptr_inc(head_q);
            beat_d     = (beat_q == LastBeat) ? '0 : beat_q + BeatW'(1);
            rd_count_d = rd_count_q + CNT_W'(1);
        end
    end

    // Leaving DRAIN looks at next-state occupancy so busy drops right after the final fire.
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (enable) state_d = StRun;
            end
            StRun: begin
                if (!enable) state_d = StDrain;
            end
            StDrain: begin
                if (enable) begin
                    state_d = StRun;
                end else if ((occ_d == 2'd0) && !inflight_d) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= StIdle;
            occ_q      <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= 2'd0;
            tail_q     <= 2'd0;
            beat_q     <= '0;
            rd_count_q <= '0;
        end else begin
            state_q    <= state_d;
            occ_q      <= occ_d;
            inflight_q <= inflight_d;
            head_q     <= head_d;
            tail_q     <= tail_d;
            beat_q     <= beat_d;
            rd_count_q <= rd_count_d;
        end
    end

    // Entries are cleared on reset so m_data reads zero until the first capture.
    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < 3; i++) begin
                buf_q[i] <= '0;
            end
        end else if (capture) begin
            buf_q[tail_q] <= data_in;
        end
    end

    assign rd_count = rd_count_q;

`ifdef SEQ_CHECK_EN
    logic [WIDTH-1:0] expected_q;
    logic             seq_err_q;

    // Expected value resyncs to the delivered word so one gap flags once, not forever.
    always_ff @(posedge clk) begin
        if (reset) begin
            expected_q <= '0;
            seq_err_q  <= 1'b0;
        end else if (fire) begin
            expected_q <= m_data + WIDTH'(1);
            if (m_data != expected_q) begin
                seq_err_q <= 1'b1;
            end
        end
    end

    assign seq_err = seq_err_q;
`else
    assign seq_err = 1'b0;
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Self-checking bench for fifo_stream_reader: directed scenarios plus randomized traffic,
// scored against an in-order word queue and burst/count arithmetic.
module tb_fifo_stream_reader;

    localparam int unsigned WIDTH     = 32;
    localparam int unsigned BURST_LEN = 4;
    localparam int unsigned CNT_W     = 16;

    logic             clk;
    logic             reset;
    logic             enable;
    logic             fifo_empty;
    logic             r_ready;
    logic [WIDTH-1:0] data_in;
    logic             m_valid;
    logic             m_ready;
    logic [WIDTH-1:0] m_data;
    logic             m_last;
    logic             busy;
    logic [CNT_W-1:0] rd_count;
    logic             seq_err;

    fifo_stream_reader #(
        .WIDTH    (WIDTH),
        .BURST_LEN(BURST_LEN),
        .CNT_W    (CNT_W)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .enable    (enable),
        .fifo_empty(fifo_empty),
        .r_ready   (r_ready),
        .data_in   (data_in),
        .m_valid   (m_valid),
        .m_ready   (m_ready),
        .m_data    (m_data),
        .m_last    (m_last),
        .busy      (busy),
        .rd_count  (rd_count),
        .seq_err   (seq_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fifo model: data_in presents the popped word one cycle after the pop, junk otherwise.
    logic [WIDTH-1:0] fmem [256];
    int               wr_ptr = 0;
    int               rd_ptr = 0;
    int               pops   = 0;
    logic             force_empty;

    assign fifo_empty = force_empty || (rd_ptr == wr_ptr);

    always @(posedge clk) begin
        if (reset) begin
            rd_ptr  <= wr_ptr;
            pops    <= 0;
            data_in <= $urandom;
        end else if (r_ready && !fifo_empty) begin
            data_in <= fmem[rd_ptr % 256];
            rd_ptr  <= rd_ptr + 1;
            pops    <= pops + 1;
        end else begin
            data_in <= $urandom;
        end
    end

    int               tests = 0;
    int               fails = 0;
    int               cyc   = 0;
    int               nfire = 0;
    int               first_pop, first_fire, last_fire;
    logic [WIDTH-1:0] exp_q [$];
    logic [WIDTH-1:0] model_exp;
    bit               model_err;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] expv);
        tests++;
        assert (obs === expv)
        else begin
            fails++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, expv);
        end
    endtask

    task automatic push(input logic [WIDTH-1:0] w);
        fmem[wr_ptr % 256] = w;
        wr_ptr = wr_ptr + 1;
        exp_q.push_back(w);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enable      = 1'b0;
        m_ready     = 1'b0;
        force_empty = 1'b0;
        @(posedge clk);
        #1;
        reset = 1'b0;
        exp_q.delete();
        nfire      = 0;
        model_exp  = '0;
        model_err  = 1'b0;
        first_pop  = -1;
        first_fire = -1;
        last_fire  = -1;
        check("rst_r_ready", r_ready, 0);
        check("rst_m_valid", m_valid, 0);
        check("rst_m_data", m_data, 0);
        check("rst_m_last", m_last, 0);
        check("rst_busy", busy, 0);
        check("rst_rd_count", rd_count, 0);
        check("rst_seq_err", seq_err, 0);
    endtask

    // One clock: score the current beat, advance, then check counters after the edge.
    task automatic step();
        logic [WIDTH-1:0] w;
        bit               fire;
        #1;
        fire = m_valid && m_ready;
        check("pop_on_empty", r_ready && fifo_empty, 0);
        if (r_ready && !fifo_empty && first_pop < 0) first_pop = cyc;
        if (exp_q.size() == 0) begin
            check("spurious_valid", m_valid, 0);
        end else if (m_valid) begin
            check("m_data", m_data, exp_q[0]);
            check("m_last", m_last, ((nfire % BURST_LEN) == BURST_LEN - 1) ? 1 : 0);
        end else begin
            check("last_idle", m_last, 0);
        end
        if (fire && exp_q.size() > 0) begin
            w = exp_q.pop_front();
            if (w != model_exp) model_err = 1'b1;
            model_exp = w + 1;
            nfire++;
            if (first_fire < 0) first_fire = cyc;
            last_fire = cyc;
        end
        @(posedge clk);
        #1;
        check("rd_count", rd_count, CNT_W'(nfire));
`ifdef SEQ_CHECK_EN
        check("seq_err", seq_err, model_err);
`else
        check("seq_err", seq_err, 0);
`endif
        check("outstanding_le3", (pops - nfire) <= 3, 1);
        cyc++;
    endtask

    initial begin
        data_in = '0;
        do_reset();

        // Enabled with an empty fifo: sits in RUN, never pops.
        enable = 1'b1;
        for (int i = 0; i < 20; i++) begin
            step();
            check("t1_r_ready", r_ready, 0);
            check("t1_m_valid", m_valid, 0);
        end
        check("t1_busy", busy, 1);
        check("t1_rd_count", rd_count, 0);

        // Full-rate streaming of 0..9.
        do_reset();
        for (int i = 0; i < 10; i++) push(WIDTH'(i));
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 40 && nfire < 10; i++) step();
        check("t2_nfire", nfire, 10);
        check("t2_rd_count", rd_count, 10);
        check("t2_latency", first_fire - first_pop, 2);
        check("t2_no_bubbles", last_fire - first_fire, 9);

        // Backpressure: only three words may be outstanding.
        do_reset();
        for (int i = 0; i < 10; i++) push(WIDTH'(i));
        enable = 1'b1;
        for (int i = 0; i < 6; i++) step();
        check("t3_pops", pops, 3);
        check("t3_r_ready", r_ready, 0);
        m_ready = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        check("t3_nfire", nfire, 10);
        check("t3_pops_all", pops, 10);

        // Drop enable while word 4 is being popped, drain, then resume.
        do_reset();
        for (int i = 0; i < 10; i++) push(WIDTH'(i));
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 30 && enable; i++) begin
            #1;
            if (r_ready && pops == 4) enable = 1'b0;
            step();
        end
        check("t4_enable_dropped", enable, 0);
        for (int i = 0; i < 20 && nfire < 5; i++) step();
        check("t4_nfire", nfire, 5);
        check("t4_busy_fall", busy, 0);
        for (int i = 0; i < 4; i++) step();
        check("t4_pops", pops, 5);
        check("t4_idle_r_ready", r_ready, 0);
        check("t4_left", exp_q.size(), 5);
        enable = 1'b1;
        for (int i = 0; i < 40 && exp_q.size() > 0; i++) step();
        check("t4_nfire_all", nfire, 10);
        check("t4_rd_count", rd_count, 10);

        // Sequence gap: 0,1,2,5,6.
        do_reset();
        push(0); push(1); push(2); push(5); push(6);
        enable  = 1'b1;
        m_ready = 1'b1;
        for (int i = 0; i < 30 && nfire < 5; i++) step();
        check("t5_nfire", nfire, 5);
`ifdef SEQ_CHECK_EN
        check("t5_seq_err_sticky", seq_err, 1);
`endif

        // Reset with occ=2 and a pop in flight.
        do_reset();
        for (int i = 0; i < 10; i++) push(WIDTH'(i));
        enable = 1'b1;
        for (int i = 0; i < 10 && pops < 3; i++) step();
        check("t6_pops", pops, 3);
        check("t6_valid_before", m_valid, 1);
        do_reset();
        m_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            step();
            check("t6_no_valid", m_valid, 0);
        end
        check("t6_rd_count", rd_count, 0);

        // Randomized traffic, backpressure, fifo stalls and enable toggling.
        do_reset();
        enable = 1'b1;
        for (int i = 0; i < 400; i++) begin
            if (($urandom % 3 != 0) && (wr_ptr - rd_ptr) < 200) push($urandom);
            m_ready     = ($urandom % 4) != 0;
            force_empty = ($urandom % 5) == 0;
            if ($urandom % 30 == 0) enable = ~enable;
            step();
        end
        force_empty = 1'b0;
        enable      = 1'b1;
        m_ready     = 1'b1;
        for (int i = 0; i < 600 && exp_q.size() > 0; i++) step();
        check("rand_drained", exp_q.size(), 0);
        check("rand_rd_count", rd_count, CNT_W'(nfire));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
